ysyx_22041211_mem_arbiter: RTL and testbench
============================================

# ysyx_22041211_mem_arbiter

Two-master, one-slave memory arbiter sitting between the instruction-fetch unit (IFU) and the load/store unit (LSU) on one side and the single shared memory port on the other. It replaces the direct, per-cycle memory read that fetch performs today with a handshaked, one-transaction-at-a-time scheduler. Arbitration is alternating priority under contention, and every transaction is bounded by a response timeout.

## Interface
- DATA_LEN, 32: data width.
- ADDR_LEN, 32: address width.
- TIMEOUT, 255: wait cycles allowed in REQ+RESP before an error response is generated (8-bit counter).
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_LEN  IFU fetch address.
- ifu_resp_valid  out  1  IFU response available.
- ifu_resp_ready  in  1  IFU consumes response.
- ifu_rdata  out  DATA_LEN  fetched instruction.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  ADDR_LEN  LSU address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  DATA_LEN  store data.
- lsu_wmask  in  4  byte-enable mask.
- lsu_resp_valid  out  1  LSU response available; also the store completion acknowledge.
- lsu_resp_ready  in  1  LSU consumes response.
- lsu_rdata  out  DATA_LEN  load data.
- resp_err  out  1  error flag; meaningful only while ifu_resp_valid or lsu_resp_valid is high.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  ADDR_LEN  latched address.
- mem_wen  out  1  latched write enable; always 0 for IFU transactions.
- mem_wdata  out  DATA_LEN  latched write data.
- mem_wmask  out  4  latched mask; 4'b1111 for IFU transactions.
- mem_resp_valid  in  1  single-cycle response pulse from memory; memory has no backpressure.
- mem_rdata  in  DATA_LEN  response data, valid with mem_resp_valid.

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE → REQ on accepting a request.
  - REQ → RESP on mem_req_ready.
  - RESP → DONE on mem_resp_valid.
  - DONE → IDLE on owner resp_ready.
- Arbitration in IDLE:
  - If only one master is valid, it wins.
  - If both are valid, the master that is not last_owner wins.
  - last_owner resets to LSU, so IFU wins the first contention.
  - The winner's req_ready is driven high combinationally in IDLE. The loser's req_ready is 0.
  - req_ready is 0 in every state other than IDLE.
- On accept:
  - Latch addr, wen, wdata and wmask. IFU forces wen=0 and wmask=4'b1111.
  - Record owner and update last_owner.
  - Clear cnt.
- REQ:
  - mem_req_valid=1.
  - mem_addr, mem_wen, mem_wdata and mem_wmask hold the latched values, stable until mem_req_ready.
- RESP:
  - On mem_resp_valid, capture mem_rdata into the response register and set err=0.
  - Writes also complete through this path; captured rdata is don't-care.
- DONE:
  - Only the owner's resp_valid=1. Both ifu_rdata and lsu_rdata are driven from the response register.
  - resp_err is driven from err.
  - The response is held until the owner's resp_ready.
- Timeout:
  - cnt increments every cycle spent in REQ or RESP without the exit event.
  - When cnt==TIMEOUT and no exit event occurs that cycle: go to DONE with err=1 and rdata=0, and drop mem_req_valid.
  - An exit event in the same cycle as cnt==TIMEOUT takes priority over the timeout.
- Requests arriving outside IDLE are not accepted. Masters hold valid, and the request is arbitrated on return to IDLE.

## Timing
- Reset (rst=0 at a rising edge):
  - state=IDLE, cnt=0, last_owner=LSU.
  - Latched request and response registers cleared to 0.
  - All ready and valid outputs read 0 while rst=0.
  - A transaction in flight is abandoned and no response is delivered.
- Minimum latency, with memory ready and responding immediately:
  - Accept in cycle 0.
  - mem_req_valid in cycle 1 with mem_req_ready the same cycle.
  - mem_resp_valid in cycle 2.
  - resp_valid in cycle 3.
  - IDLE again in cycle 4.
  - Throughput: one transaction per 4 cycles.
- Outputs are driven combinationally from the registered state, except req_ready, which also depends on the current req_valid inputs.
- Timeout response appears TIMEOUT+1 cycles after entering REQ if memory never responds.

## Test plan
- IFU-only fetch, with memory ready immediately and mem_rdata=0x00100093 in cycle 2 → ifu_resp_valid in cycle 3, ifu_rdata=0x00100093, resp_err=0, lsu_resp_valid=0.
- Both masters valid in the same cycle right after reset → IFU granted first, LSU granted at the next IDLE. Then both valid again → IFU granted (last_owner=LSU).
- LSU store with addr=0x80000010, wdata=0xDEADBEEF, wmask=4'b0011, and mem_req_ready delayed 3 cycles → mem_* fields held stable for all 4 REQ cycles, then lsu_resp_valid with resp_err=0.
- Memory never responds → ifu_resp_valid rises 256 cycles after REQ entry, with resp_err=1 and ifu_rdata=0. The next request is then served normally.
- mem_resp_valid arrives exactly in the cycle with cnt==TIMEOUT → normal response, resp_err=0.
- rst driven low while in RESP → next cycle state IDLE with all valid/ready outputs 0. A late mem_resp_valid is ignored and no resp_valid follows.

Source files
------------

// File: rtl/ysyx_22041211_mem_arbiter.sv
// ysyx_22041211_mem_arbiter
// Two-master (IFU, LSU) to one-slave memory arbiter. One transaction at a
// time, alternating priority under contention, and a bounded wait for the
// memory response that turns into an error response on expiry.
module ysyx_22041211_mem_arbiter #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  // instruction-fetch master
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_LEN-1:0] ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_LEN-1:0] ifu_rdata,
  // load/store master
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_LEN-1:0] lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_LEN-1:0] lsu_wdata,
  input  logic [3:0]          lsu_wmask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_LEN-1:0] lsu_rdata,
  output logic                resp_err,
  // shared memory port
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_wen,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic [3:0]          mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_LEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic       OWNER_IFU = 1'b0;
  localparam logic       OWNER_LSU = 1'b1;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t                state_r;
  state_t                state_nxt_s;
  logic [7:0]            cnt_r;
  logic                  owner_r;
  logic                  last_owner_r;
  logic [ADDR_LEN-1:0]   addr_r;
  logic                  wen_r;
  logic [DATA_LEN-1:0]   wdata_r;
  logic [3:0]            wmask_r;
  logic [DATA_LEN-1:0]   rdata_r;
  logic                  err_r;

  logic                  ifu_grant_s;
  logic                  lsu_grant_s;
  logic                  cnt_inc_s;
  logic                  timeout_s;
  logic                  resp_cap_s;
  logic                  done_ack_s;

  // Next-state decode: arbitration in IDLE, exit-or-timeout in REQ/RESP,
  // owner handshake in DONE. Exit events are tested before the timeout.
  always_comb begin
    state_nxt_s = state_r;
    ifu_grant_s = 1'b0;
    lsu_grant_s = 1'b0;
    cnt_inc_s   = 1'b0;
    timeout_s   = 1'b0;
    resp_cap_s  = 1'b0;
    done_ack_s  = (owner_r == OWNER_IFU) ? ifu_resp_ready : lsu_resp_ready;
    case (state_r)
      IDLE: begin
        if (ifu_req_valid && (!lsu_req_valid || (last_owner_r == OWNER_LSU))) begin
          ifu_grant_s = 1'b1;
          state_nxt_s = REQ;
        end else if (lsu_req_valid) begin
          lsu_grant_s = 1'b1;
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_nxt_s = RESP;
        end else if (cnt_r == TIMEOUT_C) begin
          timeout_s   = 1'b1;
          state_nxt_s = DONE;
        end else begin
          cnt_inc_s   = 1'b1;
          state_nxt_s = REQ;
        end
      end
      RESP: begin
        if (mem_resp_valid) begin
          resp_cap_s  = 1'b1;
          state_nxt_s = DONE;
        end else if (cnt_r == TIMEOUT_C) begin
          timeout_s   = 1'b1;
          state_nxt_s = DONE;
        end else begin
          cnt_inc_s   = 1'b1;
          state_nxt_s = RESP;
        end
      end
      DONE: begin
        if (done_ack_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, request latch, wait counter and response register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= 8'd0;
      owner_r      <= OWNER_IFU;
      last_owner_r <= OWNER_LSU;
      addr_r       <= {ADDR_LEN{1'b0}};
      wen_r        <= 1'b0;
      wdata_r      <= {DATA_LEN{1'b0}};
      wmask_r      <= 4'b0000;
      rdata_r      <= {DATA_LEN{1'b0}};
      err_r        <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (ifu_grant_s) begin
        addr_r       <= ifu_addr;
        wen_r        <= 1'b0;
        wdata_r      <= {DATA_LEN{1'b0}};
        wmask_r      <= 4'b1111;
        owner_r      <= OWNER_IFU;
        last_owner_r <= OWNER_IFU;
        cnt_r        <= 8'd0;
      end else if (lsu_grant_s) begin
        addr_r       <= lsu_addr;
        wen_r        <= lsu_wen;
        wdata_r      <= lsu_wdata;
        wmask_r      <= lsu_wmask;
        owner_r      <= OWNER_LSU;
        last_owner_r <= OWNER_LSU;
        cnt_r        <= 8'd0;
      end else if (cnt_inc_s) begin
        cnt_r <= cnt_r + 8'd1;
      end
      if (resp_cap_s) begin
        rdata_r <= mem_rdata;
        err_r   <= 1'b0;
      end else if (timeout_s) begin
        rdata_r <= {DATA_LEN{1'b0}};
        err_r   <= 1'b1;
      end
    end
  end

  // Handshake outputs are forced low while reset is asserted so an
  // abandoned transaction never shows a stray valid/ready.
  assign ifu_req_ready  = rst & ifu_grant_s;
  assign lsu_req_ready  = rst & lsu_grant_s;
  assign mem_req_valid  = rst & (state_r == REQ);
  assign ifu_resp_valid = rst & (state_r == DONE) & (owner_r == OWNER_IFU);
  assign lsu_resp_valid = rst & (state_r == DONE) & (owner_r == OWNER_LSU);

  assign mem_addr  = addr_r;
  assign mem_wen   = wen_r;
  assign mem_wdata = wdata_r;
  assign mem_wmask = wmask_r;
  assign ifu_rdata = rdata_r;
  assign lsu_rdata = rdata_r;
  assign resp_err  = err_r;

endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
// Directed self-checking bench for ysyx_22041211_mem_arbiter.
module tb_ysyx_22041211_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        resp_err;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int n_cmp = 0;
  int n_mis = 0;
  logic early;

  ysyx_22041211_mem_arbiter #(.DATA_LEN(32), .ADDR_LEN(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // compare one observed value with its expected value
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // called in the first REQ cycle: accept immediately, respond next cycle
  task automatic do_mem(input logic [31:0] d);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = d;
    tick();
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    ifu_req_valid = 1'b0; ifu_addr = 32'h0; ifu_resp_ready = 1'b0;
    lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0;
    lsu_wdata = 32'h0; lsu_wmask = 4'h0; lsu_resp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    tick();
    tick();

    // ---- reset state ----
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    settle();
    check_eq("rst_ifu_req_ready", ifu_req_ready, 1'b0);
    check_eq("rst_lsu_req_ready", lsu_req_ready, 1'b0);
    check_eq("rst_mem_req_valid", mem_req_valid, 1'b0);
    check_eq("rst_ifu_resp_valid", ifu_resp_valid, 1'b0);
    check_eq("rst_lsu_resp_valid", lsu_resp_valid, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wmask", mem_wmask, 4'h0);
    check_eq("rst_ifu_rdata", ifu_rdata, 32'h0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    rst = 1'b1;
    tick();

    // ---- IFU-only fetch, minimum latency ----
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
    settle();
    check_eq("t1_ifu_req_ready", ifu_req_ready, 1'b1);
    check_eq("t1_lsu_req_ready", lsu_req_ready, 1'b0);
    tick();
    ifu_req_valid = 1'b0;
    settle();
    check_eq("t1_c1_mem_req_valid", mem_req_valid, 1'b1);
    check_eq("t1_c1_mem_addr", mem_addr, 32'h8000_0100);
    check_eq("t1_c1_mem_wen", mem_wen, 1'b0);
    check_eq("t1_c1_mem_wmask", mem_wmask, 4'hF);
    check_eq("t1_c1_ifu_req_ready", ifu_req_ready, 1'b0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check_eq("t1_c2_mem_req_valid", mem_req_valid, 1'b0);
    mem_resp_valid = 1'b1; mem_rdata = 32'h0010_0093;
    tick();
    mem_resp_valid = 1'b0;
    check_eq("t1_c3_ifu_resp_valid", ifu_resp_valid, 1'b1);
    check_eq("t1_c3_ifu_rdata", ifu_rdata, 32'h0010_0093);
    check_eq("t1_c3_resp_err", resp_err, 1'b0);
    check_eq("t1_c3_lsu_resp_valid", lsu_resp_valid, 1'b0);
    ifu_resp_ready = 1'b1;
    tick();
    ifu_resp_ready = 1'b0;
    check_eq("t1_c4_ifu_resp_valid", ifu_resp_valid, 1'b0);

    // ---- contention right after reset, alternating priority ----
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0040; lsu_wen = 1'b0; lsu_wmask = 4'hF;
    settle();
    check_eq("t2_first_ifu_ready", ifu_req_ready, 1'b1);
    check_eq("t2_first_lsu_ready", lsu_req_ready, 1'b0);
    tick();
    ifu_req_valid = 1'b0;
    settle();
    check_eq("t2_req_lsu_ready", lsu_req_ready, 1'b0);
    do_mem(32'h1111_1111);
    check_eq("t2_ifu_resp_valid", ifu_resp_valid, 1'b1);
    check_eq("t2_ifu_rdata", ifu_rdata, 32'h1111_1111);
    ifu_resp_ready = 1'b1;
    tick();
    ifu_resp_ready = 1'b0;
    ifu_req_valid = 1'b1;
    settle();
    check_eq("t2_second_lsu_ready", lsu_req_ready, 1'b1);
    check_eq("t2_second_ifu_ready", ifu_req_ready, 1'b0);
    tick();
    lsu_req_valid = 1'b0;
    check_eq("t2_lsu_mem_addr", mem_addr, 32'h8000_0040);
    do_mem(32'h2222_2222);
    check_eq("t2_lsu_resp_valid", lsu_resp_valid, 1'b1);
    check_eq("t2_lsu_ifu_resp_valid", ifu_resp_valid, 1'b0);
    check_eq("t2_lsu_rdata", lsu_rdata, 32'h2222_2222);
    lsu_resp_ready = 1'b1;
    tick();
    lsu_resp_ready = 1'b0;
    lsu_req_valid = 1'b1;
    settle();
    check_eq("t2_third_ifu_ready", ifu_req_ready, 1'b1);
    check_eq("t2_third_lsu_ready", lsu_req_ready, 1'b0);
    tick();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    do_mem(32'h3333_3333);
    ifu_resp_ready = 1'b1;
    tick();
    ifu_resp_ready = 1'b0;

    // ---- LSU store with delayed mem_req_ready ----
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0010; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
    settle();
    check_eq("t3_lsu_req_ready", lsu_req_ready, 1'b1);
    tick();
    lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq($sformatf("t3_req%0d_valid", i), mem_req_valid, 1'b1);
      check_eq($sformatf("t3_req%0d_addr", i), mem_addr, 32'h8000_0010);
      check_eq($sformatf("t3_req%0d_wen", i), mem_wen, 1'b1);
      check_eq($sformatf("t3_req%0d_wdata", i), mem_wdata, 32'hDEAD_BEEF);
      check_eq($sformatf("t3_req%0d_wmask", i), mem_wmask, 4'b0011);
      mem_req_ready = (i == 3);
      tick();
    end
    mem_req_ready = 1'b0;
    check_eq("t3_resp_mem_req_valid", mem_req_valid, 1'b0);
    mem_resp_valid = 1'b1; mem_rdata = 32'h0;
    tick();
    mem_resp_valid = 1'b0;
    check_eq("t3_lsu_resp_valid", lsu_resp_valid, 1'b1);
    check_eq("t3_resp_err", resp_err, 1'b0);
    check_eq("t3_ifu_resp_valid", ifu_resp_valid, 1'b0);
    tick();
    check_eq("t3_lsu_resp_held", lsu_resp_valid, 1'b1);
    lsu_resp_ready = 1'b1;
    tick();
    lsu_resp_ready = 1'b0;
    check_eq("t3_lsu_resp_dropped", lsu_resp_valid, 1'b0);

    // ---- memory never responds: timeout ----
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0300;
    tick();
    ifu_req_valid = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (ifu_resp_valid) early = 1'b1;
      if (i == 255) check_eq("t4_last_req_valid", mem_req_valid, 1'b1);
      tick();
    end
    check_eq("t4_no_early_resp", early, 1'b0);
    check_eq("t4_ifu_resp_valid", ifu_resp_valid, 1'b1);
    check_eq("t4_resp_err", resp_err, 1'b1);
    check_eq("t4_ifu_rdata", ifu_rdata, 32'h0);
    check_eq("t4_mem_req_valid", mem_req_valid, 1'b0);
    ifu_resp_ready = 1'b1;
    tick();
    ifu_resp_ready = 1'b0;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0080; lsu_wen = 1'b0; lsu_wmask = 4'hF;
    settle();
    check_eq("t4_next_lsu_ready", lsu_req_ready, 1'b1);
    tick();
    lsu_req_valid = 1'b0;
    do_mem(32'h0BAD_F00D);
    check_eq("t4_next_lsu_resp_valid", lsu_resp_valid, 1'b1);
    check_eq("t4_next_resp_err", resp_err, 1'b0);
    check_eq("t4_next_lsu_rdata", lsu_rdata, 32'h0BAD_F00D);
    lsu_resp_ready = 1'b1;
    tick();
    lsu_resp_ready = 1'b0;

    // ---- response arrives in the cnt==TIMEOUT cycle ----
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0400;
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 255; i++) tick();
    check_eq("t5_not_yet_done", ifu_resp_valid, 1'b0);
    mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_resp_valid = 1'b0;
    check_eq("t5_ifu_resp_valid", ifu_resp_valid, 1'b1);
    check_eq("t5_resp_err", resp_err, 1'b0);
    check_eq("t5_ifu_rdata", ifu_rdata, 32'h1234_5678);
    ifu_resp_ready = 1'b1;
    tick();
    ifu_resp_ready = 1'b0;

    // ---- reset while in RESP ----
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0500;
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b0;
    settle();
    check_eq("t6_inrst_ifu_resp_valid", ifu_resp_valid, 1'b0);
    check_eq("t6_inrst_mem_req_valid", mem_req_valid, 1'b0);
    tick();
    rst = 1'b1;
    mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    settle();
    check_eq("t6_ifu_resp_valid", ifu_resp_valid, 1'b0);
    check_eq("t6_lsu_resp_valid", lsu_resp_valid, 1'b0);
    check_eq("t6_mem_req_valid", mem_req_valid, 1'b0);
    check_eq("t6_ifu_req_ready", ifu_req_ready, 1'b0);
    check_eq("t6_lsu_req_ready", lsu_req_ready, 1'b0);
    tick();
    mem_resp_valid = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (ifu_resp_valid || lsu_resp_valid || mem_req_valid) early = 1'b1;
      tick();
    end
    check_eq("t6_no_late_resp", early, 1'b0);
    check_eq("t6_ifu_rdata", ifu_rdata, 32'h0);
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    settle();
    check_eq("t6_post_ifu_ready", ifu_req_ready, 1'b1);
    check_eq("t6_post_lsu_ready", lsu_req_ready, 1'b0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
